// File: rtl/mem_arb_pkg.sv
// Shared types, default latencies and byte-lane helpers for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_WB_FILL} op_t;

    // Lane 0 is the most significant byte of the word.
    typedef logic [0:3][7:0] lanes_t;

    localparam int DEF_WRITE_CYCLES = 5;
    localparam int DEF_READ_CYCLES  = 4;
    localparam int DEF_CNT_W        = 3;

    function automatic lanes_t pack_word(input logic [31:0] w);
        lanes_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

    function automatic logic [31:0] unpack_lanes(input lanes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // A plain write takes precedence over the writeback flag.
    function automatic op_t decode_op(input logic w, input logic b);
        if (w)
            return OP_WRITE;
        else if (b)
            return OP_WB_FILL;
        return OP_READ;
    endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Loadable down-counter that paces the memory write and read phases.
module mem_latency_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache access to the shared memory and runs its write, read and writeback+fill timing.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of dcache priority.
//
// state | meaning
// IDLE  | sample req, pick winner, launch first memory phase
// WR    | memory write held for WRITE_CYCLES
// RD    | read address held for READ_CYCLES, data captured on the last one
// DONE  | one-cycle ack to the granted requester
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [1:0]       wb,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][31:0] wb_addr,
    input  logic [1:0][31:0] wdata,
    output logic [1:0]       ack,
    output logic [31:0]      rdata,
    output logic             busy,
    output logic [31:0]      mem_address,
    output logic             mem_write_en,
    output logic [0:3][7:0]  mem_data_in,
    input  logic [0:3][7:0]  mem_data_out
);

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);

    state_t      state, state_nxt;
    op_t         op, op_nxt, sel_op;
    logic        grant, grant_nxt, winner;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] mem_address_nxt, rdata_nxt;
    logic        mem_write_en_nxt;
    lanes_t      mem_data_in_nxt;
    logic [1:0]  ack_nxt;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_load_val;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b0;
        else if ((state != DONE) && (state_nxt == DONE))
            last_grant <= grant;
    end

    always_comb winner = (&req) ? ~last_grant : req[1];
`else
    always_comb winner = req[1];
`endif

    mem_latency_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op           <= OP_READ;
            grant        <= 1'b0;
            addr_q       <= '0;
            mem_address  <= '0;
            mem_write_en <= 1'b0;
            mem_data_in  <= '0;
            rdata        <= '0;
            ack          <= '0;
        end else begin
            state        <= state_nxt;
            op           <= op_nxt;
            grant        <= grant_nxt;
            addr_q       <= addr_nxt;
            mem_address  <= mem_address_nxt;
            mem_write_en <= mem_write_en_nxt;
            mem_data_in  <= mem_data_in_nxt;
            rdata        <= rdata_nxt;
            ack          <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        op_nxt           = op;
        grant_nxt        = grant;
        addr_nxt         = addr_q;
        mem_address_nxt  = mem_address;
        mem_write_en_nxt = mem_write_en;
        mem_data_in_nxt  = mem_data_in;
        rdata_nxt        = rdata;
        ack_nxt          = '0;
        tmr_load         = 1'b0;
        tmr_load_val     = '0;
        tmr_dec          = 1'b0;
        sel_op           = decode_op(we[winner], wb[winner]);

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = winner;
                    op_nxt    = sel_op;
                    addr_nxt  = addr[winner];
                    tmr_load  = 1'b1;
                    if (sel_op == OP_READ) begin
                        state_nxt        = RD;
                        mem_address_nxt  = addr[winner];
                        mem_write_en_nxt = 1'b0;
                        tmr_load_val     = RD_LOAD;
                    end else begin
                        state_nxt        = WR;
                        mem_address_nxt  = (sel_op == OP_WB_FILL) ? wb_addr[winner] : addr[winner];
                        mem_data_in_nxt  = pack_word(wdata[winner]);
                        mem_write_en_nxt = 1'b1;
                        tmr_load_val     = WR_LOAD;
                    end
                end
            end
            WR: begin
                if (tmr_zero) begin
                    mem_write_en_nxt = 1'b0;
                    // A writeback rolls straight into the fill read of the miss address.
                    if (op == OP_WB_FILL) begin
                        state_nxt       = RD;
                        mem_address_nxt = addr_q;
                        tmr_load        = 1'b1;
                        tmr_load_val    = RD_LOAD;
                    end else begin
                        state_nxt      = DONE;
                        ack_nxt[grant] = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RD: begin
                if (tmr_zero) begin
                    rdata_nxt      = unpack_lanes(mem_data_out);
                    state_nxt      = DONE;
                    ack_nxt[grant] = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_nxt        = IDLE;
                mem_write_en_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
